and_or_sweeper: RTL and testbench
=================================

// Module: and_or_sweeper
// PURPOSE
//  Self-checking stimulus/response stage for the (A AND B) OR C gate.
//  - Drives all 8 input combinations into the gate's A/B/C inputs, in order.
//  - Waits a settle time, then samples the gate's Q output.
//  - Compares Q against (A&B)|C and reports per-vector pass/fail plus a summary.
//  - Sits directly upstream (stimulus) and downstream (checker) of the gate; replaces the manual #10 sweep.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles each vector is held before Q is sampled; must be >=1 (elaboration-time check)
//  ERR_W          4  width of err_count; must be >=4 so a count of 8 fits
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  start      in   1      begin a sweep; sampled only in IDLE
//  A          out  1      gate input A; registered; = idx[2]
//  B          out  1      gate input B; registered; = idx[1]
//  C          out  1      gate input C; registered; = idx[0]
//  Q          in   1      gate output under check
//  busy       out  1      high from the cycle after start is accepted until DONE exits
//  done       out  1      one-cycle pulse when the sweep completes
//  pass       out  1      1 when the last completed sweep had err_count==0; held until next start
//  err_count  out  ERR_W  number of mismatching vectors, saturating
//  fail_vec   out  8      bit i set when vector i ({A,B,C}==i) mismatched
// BEHAVIOUR
//  Reset (rst_n==0 at a clk edge):
//   - state=IDLE; A=B=C=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0; idx=0.
//   - Reset mid-sweep aborts immediately, with no done pulse.
//  FSM states and transitions:
//   - IDLE: start==1 -> idx=0, {A,B,C}=000, wait_cnt=SETTLE_CYCLES, clear err_count/fail_vec/pass -> WAIT.
//   - WAIT: wait_cnt decrements each cycle; lasts exactly SETTLE_CYCLES cycles -> SAMPLE.
//   - SAMPLE (1 cycle): exp=(A&B)|C.
//     - If Q !== exp (X/Z counts as mismatch): fail_vec[idx]=1 and err_count+=1, saturating at 2^ERR_W-1.
//     - idx==7 -> DONE.
//     - Otherwise idx+=1, {A,B,C}=idx+1, reload wait_cnt -> WAIT.
//   - DONE (1 cycle): done=1; pass=(final err_count==0) -> IDLE.
//  Busy and start rules:
//   - busy=1 in WAIT, SAMPLE and DONE.
//   - start is ignored in every state except IDLE, including the DONE cycle.
//  Timing:
//   - Vector order is 000,001,...,111 with A as MSB.
//   - Each vector is held SETTLE_CYCLES+1 cycles.
//   - Take the edge that accepts start as edge 0. Vector 0 appears after edge 0.
//   - Vector i is sampled at edge (i+1)*(SETTLE_CYCLES+1).
//   - done is high in the cycle after edge 8*(SETTLE_CYCLES+1); with default settle that is the cycle after edge 16.
//   - A new start is accepted no earlier than the cycle after DONE.
//  Output stability:
//   - A/B/C change only on the edge leaving IDLE or leaving SAMPLE; never while Q is being sampled.
//   - fail_vec and err_count are valid during the DONE cycle and are held in IDLE.
// TESTING
//  1. Correct gate, SETTLE_CYCLES=1, one-cycle start pulse
//     -> A/B/C walk 000..111, 2 cycles each; done pulse once (cycle after edge 16); pass=1, err_count=0, fail_vec=8'h00.
//  2. Q tied to 0
//     -> mismatches at idx 1,3,5,6,7: fail_vec=8'b1110_1010, err_count=5, pass=0.
//  3. Faulty gate Q=A&B (missing OR C)
//     -> fail_vec=8'b0010_1010, err_count=3, pass=0.
//  4. start held high for the whole sweep and during DONE
//     -> only one sweep runs; IDLE is entered once, then a new sweep starts the next cycle because start is still high.
//  5. rst_n low for one edge while vector 011 is driven
//     -> next cycle A=B=C=0, busy=0, fail_vec=0, no done; a fresh start then completes normally with pass=1.
//  6. SETTLE_CYCLES=3, correct gate
//     -> each vector held 4 cycles; done is high in the cycle after edge 32; pass=1.

Source files
------------

// File: rtl/and_or_sweeper_if.sv
// Signal bundle between the sweeper and its surroundings: gate stimulus/response plus
// start/status.
// start is a level request: the sweeper accepts it only in IDLE, on a clock edge where it is high.
interface and_or_sweeper_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             A;
    logic             B;
    logic             C;
    logic             Q;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       fail_vec;

    modport master (
        input  start, Q,
        output A, B, C, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, Q,
        input  A, B, C, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/and_or_sweeper.sv
// Walks {A,B,C} through 000..111, waits SETTLE_CYCLES per vector, then checks Q against
// (A&B)|C. It records per-vector failures and a saturating error count.
module and_or_sweeper #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    and_or_sweeper_if.master bus,
    output logic [1:0]       o_dbg_state
);
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("SETTLE_CYCLES must be >= 1");
        end
        if (ERR_W < 4) begin : g_bad_err_w
            $error("ERR_W must be >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_c;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_count;
    logic [7:0]       r_fail_vec;

    logic             w_exp;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;
    logic [7:0]       w_fail_next;
    logic [2:0]       w_next_idx;

    // A Q of X or Z counts as a mismatch.
    assign w_exp       = (r_a & r_b) | r_c;
    assign w_mismatch  = (bus.Q !== w_exp);
    assign w_err_next  = (w_mismatch && (r_err_count != ERR_MAX)) ? r_err_count + ERR_W'(1)
                                                                  : r_err_count;
    assign w_fail_next = r_fail_vec | (w_mismatch ? (8'd1 << r_idx) : 8'd0);
    assign w_next_idx  = r_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_wait_cnt  <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_c         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_vec  <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state           <= S_WAIT;
                        r_idx             <= 3'd0;
                        {r_a, r_b, r_c}   <= 3'b000;
                        r_wait_cnt        <= CNT_LOAD;
                        r_err_count       <= '0;
                        r_fail_vec        <= 8'd0;
                        r_pass            <= 1'b0;
                        r_busy            <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    if (r_wait_cnt == CNT_W'(1)) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_err_count <= w_err_next;
                    r_fail_vec  <= w_fail_next;
                    if (r_idx == 3'd7) begin
                        // done and pass become visible together in the DONE cycle.
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_idx           <= w_next_idx;
                        {r_a, r_b, r_c} <= w_next_idx;
                        r_wait_cnt      <= CNT_LOAD;
                        r_state         <= S_WAIT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.C         = r_c;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_vec  = r_fail_vec;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_and_or_sweeper.sv
// Bench for and_or_sweeper: two instances (settle 1 and 3) driven by a behavioural gate.
// A cycle-count model of the sweep is checked every cycle, plus hand-computed literals.
module tb_and_or_sweeper;
    localparam int PER0 = 2;
    localparam int PER1 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    int   mode = 0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [1:0] dbg1;
    logic [1:0] dbg3;

    always #5 clk = ~clk;

    and_or_sweeper_if #(.ERR_W(4)) if1 ();
    and_or_sweeper_if #(.ERR_W(4)) if3 ();

    function automatic logic gate_q(input int m, input logic a, input logic b, input logic c);
        case (m)
            0:       return (a & b) | c;
            1:       return 1'b0;
            default: return a & b;
        endcase
    endfunction

    assign if1.start = start1;
    assign if3.start = start3;
    assign if1.Q = gate_q(mode, if1.A, if1.B, if1.C);
    assign if3.Q = gate_q(mode, if3.A, if3.B, if3.C);

    and_or_sweeper #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master), .o_dbg_state(dbg1));
    and_or_sweeper #(.SETTLE_CYCLES(3), .ERR_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.master), .o_dbg_state(dbg3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: cycle count since the accepting edge ----------------
    int         m_t[2]     = '{-1, -1};
    int         m_nsamp[2] = '{0, 0};
    logic [7:0] m_mask[2]  = '{8'd0, 8'd0};
    logic [2:0] m_vec[2]   = '{3'd0, 3'd0};
    logic       m_pass[2]  = '{1'b0, 1'b0};

    function automatic int per_of(input int d);
        return (d == 0) ? PER0 : PER1;
    endfunction

    function automatic logic [7:0] sweep_mask(input int m);
        logic [7:0] r;
        logic [2:0] v;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            r[i] = (gate_q(m, v[2], v[1], v[0]) != ((v[2] & v[1]) | v[0]));
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_fail(input logic [7:0] mask, input int n);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) if (i < n) r[i] = mask[i];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   t;
            int   p;
            logic st;
            p  = per_of(d);
            st = (d == 0) ? start1 : start3;
            if (!rst_n) begin
                m_t[d]     <= -1;
                m_vec[d]   <= 3'd0;
                m_nsamp[d] <= 0;
                m_pass[d]  <= 1'b0;
                m_mask[d]  <= 8'd0;
            end else if (m_t[d] < 0) begin
                if (st) begin
                    m_t[d]     <= 0;
                    m_mask[d]  <= sweep_mask(mode);
                    m_vec[d]   <= 3'd0;
                    m_nsamp[d] <= 0;
                    m_pass[d]  <= 1'b0;
                end
            end else begin
                t = m_t[d] + 1;
                m_vec[d]   <= (t / p > 7) ? 3'd7 : 3'(t / p);
                m_nsamp[d] <= (t / p > 8) ? 8 : t / p;
                if (t == 8 * p) m_pass[d] <= (m_mask[d] == 8'd0);
                m_t[d] <= (t == 8 * p + 1) ? -1 : t;
            end
        end
    end

    task automatic compare_dut(input int d, input logic busy, input logic done, input logic pass,
                               input logic [3:0] err, input logic [7:0] fail, input logic [2:0] abc);
        logic [7:0] ef;
        ef = exp_fail(m_mask[d], m_nsamp[d]);
        check($sformatf("busy_d%0d", d), 32'(busy), 32'(m_t[d] >= 0));
        check($sformatf("done_d%0d", d), 32'(done), 32'(m_t[d] == 8 * per_of(d)));
        check($sformatf("abc_d%0d", d), 32'(abc), 32'(m_vec[d]));
        check($sformatf("fail_vec_d%0d", d), 32'(fail), 32'(ef));
        check($sformatf("err_count_d%0d", d), 32'(err), 32'($countones(ef)));
        check($sformatf("pass_d%0d", d), 32'(pass), 32'(m_pass[d]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_dut(0, if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_vec,
                        {if1.A, if1.B, if1.C});
            compare_dut(1, if3.busy, if3.done, if3.pass, if3.err_count, if3.fail_vec,
                        {if3.A, if3.B, if3.C});
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic dut_done(input int d);
        return (d == 0) ? if1.done : if3.done;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) start1 = v;
        else        start3 = v;
    endtask

    task automatic wait_done(input int d, input int budget, output int n);
        n = 0;
        while (n < budget && !dut_done(d)) begin
            @(negedge clk);
            n++;
        end
        if (!dut_done(d)) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout dut=%0d waited=%0d cycles", d, n);
        end
    endtask

    // Returns at the negedge of the done cycle; n counts edges after the accepting edge.
    task automatic run_sweep(input int d, input bit hold, input int budget, output int n);
        @(negedge clk);
        set_start(d, 1'b1);
        @(negedge clk);
        if (!hold) set_start(d, 1'b0);
        wait_done(d, budget, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(if1.busy), 32'd0);
        check("rst_abc", 32'({if1.A, if1.B, if1.C}), 32'd0);
        check("rst_fail_vec", 32'(if1.fail_vec), 32'd0);
        check("rst_err_pass", 32'({if1.err_count, if1.pass, if1.done}), 32'd0);
        rst_n = 1'b1;

        // 1: correct gate
        mode = 0;
        run_sweep(0, 1'b0, 40, n);
        check("t1_done_edge", 32'(n), 32'd16);
        check("t1_pass", 32'(if1.pass), 32'd1);
        check("t1_err", 32'(if1.err_count), 32'd0);
        check("t1_fail_vec", 32'(if1.fail_vec), 32'h00);
        @(negedge clk);

        // 2: Q stuck at 0
        mode = 1;
        run_sweep(0, 1'b0, 40, n);
        check("t2_fail_vec", 32'(if1.fail_vec), 32'hEA);
        check("t2_err", 32'(if1.err_count), 32'd5);
        check("t2_pass", 32'(if1.pass), 32'd0);
        @(negedge clk);
        check("t2_held_fail_vec", 32'(if1.fail_vec), 32'hEA);

        // 3: gate missing the OR C term
        mode = 2;
        run_sweep(0, 1'b0, 40, n);
        check("t3_fail_vec", 32'(if1.fail_vec), 32'h2A);
        check("t3_err", 32'(if1.err_count), 32'd3);
        check("t3_pass", 32'(if1.pass), 32'd0);
        @(negedge clk);

        // 4: start held through the sweep and DONE
        mode = 0;
        run_sweep(0, 1'b1, 40, n);
        check("t4_done_edge", 32'(n), 32'd16);
        @(negedge clk);
        check("t4_idle_once", 32'(if1.busy), 32'd0);
        @(negedge clk);
        check("t4_restart", 32'(if1.busy), 32'd1);
        start1 = 1'b0;
        wait_done(0, 40, n);
        check("t4_second_pass", 32'(if1.pass), 32'd1);
        @(negedge clk);

        // 5: reset while vector 011 is driven
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (n < 20 && {if1.A, if1.B, if1.C} != 3'b011) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_011", 32'({if1.A, if1.B, if1.C}), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_abc", 32'({if1.A, if1.B, if1.C}), 32'd0);
        check("t5_busy", 32'(if1.busy), 32'd0);
        check("t5_fail_vec", 32'(if1.fail_vec), 32'd0);
        repeat (3) @(negedge clk);
        run_sweep(0, 1'b0, 40, n);
        check("t5_pass", 32'(if1.pass), 32'd1);
        @(negedge clk);

        // 6: settle of 3 cycles
        mode = 0;
        run_sweep(1, 1'b0, 80, n);
        check("t6_done_edge", 32'(n), 32'd32);
        check("t6_pass", 32'(if3.pass), 32'd1);
        check("t6_fail_vec", 32'(if3.fail_vec), 32'h00);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
